// File: rtl/cti_pkg.sv
// -----------------------------------------------------------------------------
// cti_pkg
// Shared definitions for the counter-update pipeline.
//   cti_op_e  : update operation (encoding 3 is reserved and acts as a
//               rewrite of the current value)
//   cti_req_t : queued request {addr, op} for the default 16-entry RAM;
//               cti_counter_updater declares the same layout sized by INDEX
// -----------------------------------------------------------------------------
package cti_pkg;

   typedef enum logic [1:0] {
      CTI_INC = 2'd0,
      CTI_DEC = 2'd1,
      CTI_CLR = 2'd2
   } cti_op_e;

   localparam int unsigned CTI_DEF_INDEX = 4;

   typedef struct packed {
      logic [CTI_DEF_INDEX-1:0] addr;
      cti_op_e                  op;
   } cti_req_t;

endpackage

// File: rtl/cti_upd_fifo.sv
// -----------------------------------------------------------------------------
// cti_upd_fifo
// QDEPTH-entry synchronous request FIFO with flush.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   push, din   : write request (ignored when full)
//   pop         : remove head (ignored when empty)
//   flush       : empty the queue at the next edge, dropping a same-cycle push
//   head        : current head entry
//   empty, full : occupancy flags
// -----------------------------------------------------------------------------
module cti_upd_fifo
   import cti_pkg::*;
#(
   parameter int unsigned QDEPTH = 4,
   parameter type         T      = cti_req_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     din,
   input  logic pop,
   input  logic flush,
   output T     head,
   output logic empty,
   output logic full
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   T               mem [QDEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(QDEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage is not reset; a flushed slot is simply overwritten later.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cti_counter_updater.sv
// -----------------------------------------------------------------------------
// cti_counter_updater
// Queues counter update requests and applies them to an external counter RAM
// with a read/compute stage and a registered write stage, one update per cycle.
// Ports:
//   clk, reset                  : clock, synchronous active-low reset
//   upd_valid_i/upd_ready_o     : request handshake
//   upd_addr_i, upd_op_i        : counter index and operation (INC/DEC/CLR)
//   flush_i                     : discard queued, not-yet-read requests
//   ram_rd_addr_o/ram_rd_data_i : combinational-read RAM port
//   ram_wr_addr_o/ram_wr_data_o/ram_we_o : RAM write port
//   sat_o                       : saturation pulse aligned with ram_we_o
//   idle_o                      : queue empty and no write pending
// -----------------------------------------------------------------------------
module cti_counter_updater
   import cti_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned INDEX  = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned QDEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             upd_valid_i,
   output logic             upd_ready_o,
   input  logic [INDEX-1:0] upd_addr_i,
   input  logic [1:0]       upd_op_i,
   input  logic             flush_i,
   output logic [INDEX-1:0] ram_rd_addr_o,
   input  logic [WIDTH-1:0] ram_rd_data_i,
   output logic [INDEX-1:0] ram_wr_addr_o,
   output logic [WIDTH-1:0] ram_wr_data_o,
   output logic             ram_we_o,
   output logic             sat_o,
   output logic             idle_o
);

   typedef struct packed {
      logic [INDEX-1:0] addr;
      cti_op_e          op;
   } upd_req_t;

   upd_req_t         push_req;
   upd_req_t         head;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             fwd_hit;
   logic [WIDTH-1:0] old_val;
   logic [WIDTH-1:0] new_val;
   logic             new_sat;
   logic [INDEX-1:0] rd_addr_q;

   assign push_req = '{addr: upd_addr_i, op: cti_op_e'(upd_op_i)};

   // Ready is forced low while reset is sampled low, and rises as soon as it is released.
   assign upd_ready_o = reset && !full;
   assign push        = upd_valid_i && upd_ready_o;
   // A flush wins over the read stage: the head is discarded, not processed.
   assign pop         = !empty && !flush_i;

   cti_upd_fifo #(
      .QDEPTH (QDEPTH),
      .T      (upd_req_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_req),
      .pop   (pop),
      .flush (flush_i),
      .head  (head),
      .empty (empty),
      .full  (full)
   );

   assign ram_rd_addr_o = empty ? rd_addr_q : head.addr;

   // The RAM still holds the pre-write value while the write stage is busy,
   // so a same-address read takes the value from the write register instead.
   assign fwd_hit = ram_we_o && (ram_wr_addr_o == head.addr);
   assign old_val = fwd_hit ? ram_wr_data_o : ram_rd_data_i;

   always_comb begin
      new_val = old_val;
      new_sat = 1'b0;
      case (head.op)
         CTI_INC: begin
            if (old_val == '1) new_sat = 1'b1;
            else               new_val = old_val + WIDTH'(1);
         end
         CTI_DEC: begin
            if (old_val == '0) new_sat = 1'b1;
            else               new_val = old_val - WIDTH'(1);
         end
         CTI_CLR: new_val = '0;
         default: new_val = old_val;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ram_we_o      <= 1'b0;
         sat_o         <= 1'b0;
         ram_wr_addr_o <= '0;
         ram_wr_data_o <= '0;
         rd_addr_q     <= '0;
      end else begin
         ram_we_o  <= pop;
         sat_o     <= pop && new_sat;
         rd_addr_q <= ram_rd_addr_o;
         if (pop) begin
            ram_wr_addr_o <= head.addr;
            ram_wr_data_o <= new_val;
         end
      end
   end

   assign idle_o = empty && !ram_we_o;

endmodule

// File: tb/tb_cti_counter_updater.sv
// -----------------------------------------------------------------------------
// tb_cti_counter_updater
// Directed bench for cti_counter_updater with a behavioural counter RAM.
// -----------------------------------------------------------------------------
module tb_cti_counter_updater;

   logic       clk = 1'b0;
   logic       reset;
   logic       upd_valid;
   logic       upd_ready;
   logic [3:0] upd_addr;
   logic [1:0] upd_op;
   logic       flush;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       we;
   logic       sat;
   logic       idle;

   logic       ld_en;
   logic [3:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] ram [16];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cti_counter_updater #(
      .DEPTH  (16),
      .INDEX  (4),
      .WIDTH  (8),
      .QDEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .upd_valid_i   (upd_valid),
      .upd_ready_o   (upd_ready),
      .upd_addr_i    (upd_addr),
      .upd_op_i      (upd_op),
      .flush_i       (flush),
      .ram_rd_addr_o (rd_addr),
      .ram_rd_data_i (rd_data),
      .ram_wr_addr_o (wr_addr),
      .ram_wr_data_o (wr_data),
      .ram_we_o      (we),
      .sat_o         (sat),
      .idle_o        (idle)
   );

   // Counter RAM: combinational read, write at posedge; ld_* preloads it.
   assign rd_data = ram[rd_addr];
   always @(posedge clk) begin
      if (ld_en)   ram[ld_addr] <= ld_data;
      else if (we) ram[wr_addr] <= wr_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated request: write appears in the second cycle after acceptance.
   task automatic single(input string tag, input logic [3:0] a, input logic [1:0] op,
                         input logic [7:0] d, input logic s);
      upd_valid = 1'b1; upd_addr = a; upd_op = op;
      tick();
      upd_valid = 1'b0;
      check_eq({tag, "_we_early"}, 32'(we), 32'd0);
      tick();
      check_eq({tag, "_we"},   32'(we),      32'd1);
      check_eq({tag, "_addr"}, 32'(wr_addr), 32'(a));
      check_eq({tag, "_data"}, 32'(wr_data), 32'(d));
      check_eq({tag, "_sat"},  32'(sat),     32'(s));
      tick();
      check_eq({tag, "_we_off"},  32'(we),      32'd0);
      check_eq({tag, "_sat_off"}, 32'(sat),     32'd0);
      check_eq({tag, "_idle"},    32'(idle),    32'd1);
      check_eq({tag, "_ram"},     32'(ram[a]),  32'(d));
      check_eq({tag, "_rdhold"},  32'(rd_addr), 32'(a));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] list5 [5];
      list5 = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5};
      reset = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_op = '0; flush = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;

      // Preload RAM while reset is held.
      for (int i = 0; i < 16; i++) begin
         ld_en = 1'b1; ld_addr = 4'(i);
         ld_data = (i == 3) ? 8'd5 : (i == 9) ? 8'd255 : 8'd0;
         tick();
      end
      ld_en = 1'b0;
      tick();

      check_eq("rst_ready",   32'(upd_ready), 32'd0);
      check_eq("rst_idle",    32'(idle),      32'd1);
      check_eq("rst_we",      32'(we),        32'd0);
      check_eq("rst_sat",     32'(sat),       32'd0);
      check_eq("rst_wr_addr", 32'(wr_addr),   32'd0);
      check_eq("rst_wr_data", 32'(wr_data),   32'd0);
      check_eq("rst_rd_addr", 32'(rd_addr),   32'd0);

      reset = 1'b1;
      tick();
      check_eq("rel_ready", 32'(upd_ready), 32'd1);

      single("inc3",  4'd3,  2'd0, 8'd6,   1'b0);
      single("inc_max",  4'd9,  2'd0, 8'd255, 1'b1);
      single("dec_zero", 4'd10, 2'd1, 8'd0,   1'b1);
      single("clr_zero", 4'd10, 2'd2, 8'd0,   1'b0);
      single("dec3",  4'd3,  2'd1, 8'd5,   1'b0);
      single("rsvd3", 4'd3,  2'd3, 8'd5,   1'b0);

      // Four back-to-back INC to addr 7.
      upd_valid = 1'b1; upd_addr = 4'd7; upd_op = 2'd0;
      tick();
      check_eq("b2b_we0", 32'(we), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) upd_valid = 1'b0;
         tick();
         check_eq("b2b_we",   32'(we),      32'd1);
         check_eq("b2b_addr", 32'(wr_addr), 32'd7);
         check_eq("b2b_data", 32'(wr_data), 32'(i));
      end
      tick();
      check_eq("b2b_done", 32'(we),     32'd0);
      check_eq("b2b_ram7", 32'(ram[7]), 32'd4);

      // INC then DEC on the same address: DEC must see the forwarded 1.
      upd_valid = 1'b1; upd_addr = 4'd11; upd_op = 2'd0;
      tick();
      upd_op = 2'd1;
      tick();
      upd_valid = 1'b0;
      check_eq("incdec_d1", 32'(wr_data), 32'd1);
      check_eq("incdec_s1", 32'(sat),     32'd0);
      tick();
      check_eq("incdec_we2", 32'(we),      32'd1);
      check_eq("incdec_d2",  32'(wr_data), 32'd0);
      check_eq("incdec_s2",  32'(sat),     32'd0);
      tick();
      check_eq("incdec_ram", 32'(ram[11]), 32'd0);

      // Five back-to-back pushes: head popped every cycle, ready never drops.
      upd_valid = 1'b1; upd_op = 2'd0;
      for (int k = 0; k < 5; k++) begin
         upd_addr = list5[k];
         #1;
         check_eq("p5_ready", 32'(upd_ready), 32'd1);
         tick();
         if (k >= 1) begin
            check_eq("p5_we",   32'(we),      32'd1);
            check_eq("p5_addr", 32'(wr_addr), 32'(list5[k-1]));
         end
      end
      upd_valid = 1'b0;
      tick();
      check_eq("p5_we_last",   32'(we),      32'd1);
      check_eq("p5_addr_last", 32'(wr_addr), 32'd5);
      tick();
      check_eq("p5_idle", 32'(idle), 32'd1);
      for (int k = 0; k < 5; k++) check_eq("p5_ram", 32'(ram[list5[k]]), 32'd1);

      // Flush: only the write already in the write stage lands.
      upd_valid = 1'b1; upd_addr = 4'd13; upd_op = 2'd0;
      tick();
      check_eq("fl_we0", 32'(we), 32'd0);
      upd_addr = 4'd14;
      tick();
      check_eq("fl_we1",   32'(we),      32'd1);
      check_eq("fl_addr1", 32'(wr_addr), 32'd13);
      upd_addr = 4'd15; flush = 1'b1;
      tick();
      upd_valid = 1'b0; flush = 1'b0;
      check_eq("fl_we2",   32'(we),   32'd0);
      check_eq("fl_idle2", 32'(idle), 32'd1);
      tick();
      check_eq("fl_we3",   32'(we),      32'd0);
      check_eq("fl_idle3", 32'(idle),    32'd1);
      check_eq("fl_ram13", 32'(ram[13]), 32'd1);
      check_eq("fl_ram14", 32'(ram[14]), 32'd0);
      check_eq("fl_ram15", 32'(ram[15]), 32'd0);

      // Reset mid-operation: one write in flight, one request queued.
      upd_valid = 1'b1; upd_addr = 4'd6; upd_op = 2'd0;
      tick();
      upd_addr = 4'd8;
      tick();
      check_eq("mr_we",   32'(we),      32'd1);
      check_eq("mr_addr", 32'(wr_addr), 32'd6);
      upd_addr = 4'd2; reset = 1'b0;
      tick();
      check_eq("mr_we_r",      32'(we),        32'd0);
      check_eq("mr_sat_r",     32'(sat),       32'd0);
      check_eq("mr_wr_addr_r", 32'(wr_addr),   32'd0);
      check_eq("mr_wr_data_r", 32'(wr_data),   32'd0);
      check_eq("mr_rd_addr_r", 32'(rd_addr),   32'd0);
      check_eq("mr_ready_r",   32'(upd_ready), 32'd0);
      check_eq("mr_idle_r",    32'(idle),      32'd1);
      tick();
      check_eq("mr_we_r2", 32'(we), 32'd0);
      reset = 1'b1; upd_valid = 1'b0;
      tick();
      check_eq("mr_ready_rel", 32'(upd_ready), 32'd1);
      check_eq("mr_we_rel",    32'(we),        32'd0);
      check_eq("mr_idle_rel",  32'(idle),      32'd1);
      tick();
      check_eq("mr_we_rel2", 32'(we),     32'd0);
      check_eq("mr_ram6",    32'(ram[6]), 32'd1);
      check_eq("mr_ram8",    32'(ram[8]), 32'd0);
      check_eq("mr_ram2",    32'(ram[2]), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
